// File: rtl/coo_aggregate_server_if.sv
// Bundle between the COO aggregate server, the FM*WM product memory and the argmax stage.
// master modport is the aggregate server; slave modport is the surrounding datapath.
// Edge list, product row and served aggregated row are carried as packed arrays.
interface coo_aggregate_server_if #(
   parameter int WEIGHT_COLS     = 3,
   parameter int DOT_PROD_WIDTH  = 16,
   parameter int COO_NUM_OF_COLS = 6,
   parameter int COO_NUM_OF_ROWS = 2,
   parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
);
   logic                                                       start;
   logic [0:COO_NUM_OF_ROWS-1][0:COO_NUM_OF_COLS-1][COO_BW-1:0] coo_in;
   logic [COO_BW-1:0]                                          read_row_fm_wm;
   logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]                 fm_wm_row_in;
   logic                                                       argmax_start;
   logic [COO_BW-1:0]                                          read_row_arg;
   logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]                 adj_fm_wm_row;
   logic                                                       argmax_done;
   logic                                                       busy;

   modport master (
      input  start, coo_in, fm_wm_row_in, read_row_arg, argmax_done,
      output read_row_fm_wm, argmax_start, adj_fm_wm_row, busy
   );

   modport slave (
      output start, coo_in, fm_wm_row_in, read_row_arg, argmax_done,
      input  read_row_fm_wm, argmax_start, adj_fm_wm_row, busy
   );
endinterface

// File: rtl/coo_aggregate_server.sv
// Walks the COO edge list, summing FM*WM rows into a per-node buffer, then serves rows to argmax.
// Latency: argmax_start rises 1 + 2*COO_NUM_OF_COLS cycles after start is sampled (clear + two reads per edge).
// No backpressure: start is ignored while busy, argmax_done only ends SERVE; row reads are combinational.
module coo_aggregate_server #(
   parameter int FEATURE_ROWS    = 6,
   parameter int WEIGHT_COLS     = 3,
   parameter int DOT_PROD_WIDTH  = 16,
   parameter int NUM_OF_NODES    = 6,
   parameter int COO_NUM_OF_COLS = 6,
   parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
   parameter int EDGE_CNT_WIDTH  = $clog2(COO_NUM_OF_COLS) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   coo_aggregate_server_if.master    bus
);

   typedef enum logic [2:0] {IDLE, CLEAR, ACC_A, ACC_B, SERVE} state_t;

   // An edge contributes only if both endpoints are real buffer rows with a product row behind them.
   localparam int              VALID_NODES = (FEATURE_ROWS < NUM_OF_NODES) ? FEATURE_ROWS : NUM_OF_NODES;
   localparam logic [COO_BW:0] EDGE_LIM    = (COO_BW+1)'(VALID_NODES);
   localparam logic [COO_BW:0] SERVE_LIM   = (COO_BW+1)'(NUM_OF_NODES);
   localparam logic [EDGE_CNT_WIDTH-1:0] LAST_EDGE = EDGE_CNT_WIDTH'(COO_NUM_OF_COLS - 1);

   state_t                      state;
   logic [EDGE_CNT_WIDTH-1:0]   edge_cnt;
   logic [DOT_PROD_WIDTH-1:0]   agg [NUM_OF_NODES][WEIGHT_COLS];
   logic                        busy_q;
   logic                        argmax_start_q;
   logic [COO_BW-1:0]           rd_row_q;

   logic [COO_BW-1:0]           idx;
   logic [COO_BW-1:0]           nxt_idx;
   logic [COO_BW-1:0]           cur_a;
   logic [COO_BW-1:0]           cur_b;
   logic [COO_BW-1:0]           nxt_b;
   logic                        edge_ok;

   // Decode the current edge endpoints and the next edge's b for the read-address prefetch.
   always_comb begin
      idx     = edge_cnt[COO_BW-1:0];
      nxt_idx = idx + COO_BW'(1);
      cur_a   = bus.coo_in[0][idx];
      cur_b   = bus.coo_in[1][idx];
      nxt_b   = bus.coo_in[1][nxt_idx];
      edge_ok = ({1'b0, cur_a} < EDGE_LIM) && ({1'b0, cur_b} < EDGE_LIM);
   end

   // Control FSM and aggregation buffer; the product-memory address is registered one state ahead.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         edge_cnt       <= '0;
         busy_q         <= 1'b0;
         argmax_start_q <= 1'b0;
         rd_row_q       <= '0;
         for (int n = 0; n < NUM_OF_NODES; n++)
            for (int k = 0; k < WEIGHT_COLS; k++)
               agg[n][k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= CLEAR;
                  busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               for (int n = 0; n < NUM_OF_NODES; n++)
                  for (int k = 0; k < WEIGHT_COLS; k++)
                     agg[n][k] <= '0;
               edge_cnt <= '0;
               rd_row_q <= bus.coo_in[1][0];
               state    <= ACC_A;
            end
            ACC_A: begin
               if (edge_ok)
                  for (int k = 0; k < WEIGHT_COLS; k++)
                     agg[cur_a][k] <= agg[cur_a][k] + bus.fm_wm_row_in[k];
               rd_row_q <= cur_a;
               state    <= ACC_B;
            end
            ACC_B: begin
               // A self-loop was already counted once in ACC_A.
               if (edge_ok && (cur_a != cur_b))
                  for (int k = 0; k < WEIGHT_COLS; k++)
                     agg[cur_b][k] <= agg[cur_b][k] + bus.fm_wm_row_in[k];
               edge_cnt <= edge_cnt + EDGE_CNT_WIDTH'(1);
               if (edge_cnt == LAST_EDGE) begin
                  rd_row_q       <= '0;
                  argmax_start_q <= 1'b1;
                  state          <= SERVE;
               end else begin
                  rd_row_q <= nxt_b;
                  state    <= ACC_A;
               end
            end
            SERVE: begin
               if (bus.argmax_done) begin
                  argmax_start_q <= 1'b0;
                  busy_q         <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Serve the requested aggregated row; rows outside the buffer read as zero.
   always_comb begin
      bus.adj_fm_wm_row = '0;
      if ({1'b0, bus.read_row_arg} < SERVE_LIM)
         for (int k = 0; k < WEIGHT_COLS; k++)
            bus.adj_fm_wm_row[k] = agg[bus.read_row_arg][k];
   end

   assign bus.read_row_fm_wm = rd_row_q;
   assign bus.argmax_start   = argmax_start_q;
   assign bus.busy           = busy_q;

endmodule

// File: tb/tb_coo_aggregate_server.sv
// Bench for coo_aggregate_server: directed scenarios plus randomized edge lists
// checked against an edge-by-edge summation model of the aggregated buffer.
module tb_coo_aggregate_server;
   localparam int WC = 3;
   localparam int NC = 6;

   logic clk;
   logic reset;

   coo_aggregate_server_if bus();

   coo_aggregate_server dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] fm_mem  [0:5][0:WC-1];
   logic [15:0] exp_row [0:7][0:WC-1];
   int          edge_a  [NC];
   int          edge_b  [NC];
   int          check_cnt = 0;
   int          pass_cnt  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Product memory model: combinational read, absent rows read as zero.
   always_comb begin
      for (int k = 0; k < WC; k++)
         bus.fm_wm_row_in[k] = (bus.read_row_fm_wm < 3'd6) ? fm_mem[bus.read_row_fm_wm][k] : 16'h0;
   end

   task automatic load_edges();
      for (int e = 0; e < NC; e++) begin
         bus.coo_in[0][e] = 3'(edge_a[e]);
         bus.coo_in[1][e] = 3'(edge_b[e]);
      end
   endtask

   task automatic set_ring_rows();
      for (int i = 0; i < 6; i++) begin
         fm_mem[i][0] = 16'(i + 1);
         fm_mem[i][1] = 16'(10 * (i + 1));
         fm_mem[i][2] = 16'(100 * (i + 1));
      end
   endtask

   // Each edge (a,b) adds node b's row to a and node a's row to b (once for a self-loop);
   // edges touching a non-existent node contribute nothing.
   function automatic void compute_model();
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < WC; k++)
            exp_row[r][k] = 16'h0;
      for (int e = 0; e < NC; e++) begin
         if (edge_a[e] < 6 && edge_b[e] < 6) begin
            for (int k = 0; k < WC; k++) begin
               exp_row[edge_a[e]][k] = exp_row[edge_a[e]][k] + fm_mem[edge_b[e]][k];
               if (edge_a[e] != edge_b[e])
                  exp_row[edge_b[e]][k] = exp_row[edge_b[e]][k] + fm_mem[edge_a[e]][k];
            end
         end
      end
   endfunction

   // Pulse (or hold) start and count edges until argmax_start is seen; -1 if it never comes.
   task automatic run_agg(input bit hold, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.argmax_start === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic finish_serve();
      @(negedge clk);
      bus.argmax_done = 1'b1;
      @(negedge clk);
      bus.argmax_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
      check_cnt++;
      if (bus.argmax_start !== 1'b0) $display("FAIL reset_argmax_start got %b want 0", bus.argmax_start); else pass_cnt++;
      check_cnt++;
      if (bus.read_row_fm_wm !== 3'd0) $display("FAIL reset_read_row got %0d want 0", bus.read_row_fm_wm); else pass_cnt++;
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         bus.read_row_arg = 3'(r);
         #1;
         for (int k = 0; k < WC; k++) begin
            check_cnt++;
            if (bus.adj_fm_wm_row[k] !== 16'h0)
               $display("FAIL reset_row r%0d k%0d got %0d want 0", r, k, bus.adj_fm_wm_row[k]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_ring();
      int lat;
      set_ring_rows();
      for (int e = 0; e < NC; e++) begin
         edge_a[e] = e;
         edge_b[e] = (e + 1) % 6;
      end
      load_edges();
      compute_model();
      run_agg(1'b0, lat);
      check_cnt++;
      if (lat != 13) $display("FAIL ring_latency got %0d want 13", lat); else pass_cnt++;
      check_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL ring_busy got %b want 1", bus.busy); else pass_cnt++;
      @(negedge clk);
      bus.read_row_arg = 3'd0;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row !== {16'd8, 16'd80, 16'd800})
         $display("FAIL ring_row0 got %h want 8/80/800", bus.adj_fm_wm_row);
      else pass_cnt++;
      bus.read_row_arg = 3'd3;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row !== {16'd8, 16'd80, 16'd800})
         $display("FAIL ring_row3 got %h want 8/80/800", bus.adj_fm_wm_row);
      else pass_cnt++;
      bus.read_row_arg = 3'd1;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row !== {16'd4, 16'd40, 16'd400})
         $display("FAIL ring_row1 got %h want 4/40/400", bus.adj_fm_wm_row);
      else pass_cnt++;
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         bus.read_row_arg = 3'(r);
         #1;
         for (int k = 0; k < WC; k++) begin
            check_cnt++;
            if (bus.adj_fm_wm_row[k] !== exp_row[r][k])
               $display("FAIL ring_model r%0d k%0d got %0d want %0d", r, k, bus.adj_fm_wm_row[k], exp_row[r][k]);
            else pass_cnt++;
         end
      end
      finish_serve();
      check_cnt++;
      if (bus.argmax_start !== 1'b0) $display("FAIL ring_done_start got %b want 0", bus.argmax_start); else pass_cnt++;
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL ring_done_busy got %b want 0", bus.busy); else pass_cnt++;
      bus.read_row_arg = 3'd0;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row[0] !== 16'd8) $display("FAIL ring_retained got %0d want 8", bus.adj_fm_wm_row[0]); else pass_cnt++;
   endtask

   task automatic test_self_loop();
      int lat;
      set_ring_rows();
      for (int e = 0; e < NC; e++) begin
         edge_a[e] = 2;
         edge_b[e] = 2;
      end
      load_edges();
      compute_model();
      run_agg(1'b0, lat);
      check_cnt++;
      if (lat != 13) $display("FAIL self_latency got %0d want 13", lat); else pass_cnt++;
      @(negedge clk);
      bus.read_row_arg = 3'd2;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row !== {16'd18, 16'd180, 16'd1800})
         $display("FAIL self_row2 got %h want 18/180/1800", bus.adj_fm_wm_row);
      else pass_cnt++;
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         bus.read_row_arg = 3'(r);
         #1;
         for (int k = 0; k < WC; k++) begin
            check_cnt++;
            if (bus.adj_fm_wm_row[k] !== exp_row[r][k])
               $display("FAIL self_model r%0d k%0d got %0d want %0d", r, k, bus.adj_fm_wm_row[k], exp_row[r][k]);
            else pass_cnt++;
         end
      end
      finish_serve();
   endtask

   task automatic test_invalid();
      int lat;
      set_ring_rows();
      edge_a[0] = 7;
      edge_b[0] = 1;
      for (int e = 1; e < NC; e++) begin
         edge_a[e] = 0;
         edge_b[e] = 0;
      end
      load_edges();
      compute_model();
      run_agg(1'b0, lat);
      check_cnt++;
      if (lat != 13) $display("FAIL invalid_latency got %0d want 13", lat); else pass_cnt++;
      @(negedge clk);
      bus.read_row_arg = 3'd1;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row !== {16'd0, 16'd0, 16'd0})
         $display("FAIL invalid_row1 got %h want 0", bus.adj_fm_wm_row);
      else pass_cnt++;
      bus.read_row_arg = 3'd7;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row !== {16'd0, 16'd0, 16'd0})
         $display("FAIL invalid_row7 got %h want 0", bus.adj_fm_wm_row);
      else pass_cnt++;
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         bus.read_row_arg = 3'(r);
         #1;
         for (int k = 0; k < WC; k++) begin
            check_cnt++;
            if (bus.adj_fm_wm_row[k] !== exp_row[r][k])
               $display("FAIL invalid_model r%0d k%0d got %0d want %0d", r, k, bus.adj_fm_wm_row[k], exp_row[r][k]);
            else pass_cnt++;
         end
      end
      finish_serve();
   endtask

   task automatic test_wrap();
      int lat;
      for (int i = 0; i < 6; i++)
         for (int k = 0; k < WC; k++)
            fm_mem[i][k] = 16'($urandom);
      fm_mem[1][0] = 16'hFFFF;
      fm_mem[1][1] = 16'h0001;
      fm_mem[1][2] = 16'h0000;
      for (int k = 0; k < WC; k++) fm_mem[5][k] = 16'h0;
      for (int e = 0; e < NC; e++) begin
         edge_a[e] = (e < 2) ? 0 : 5;
         edge_b[e] = (e < 2) ? 1 : 5;
      end
      load_edges();
      compute_model();
      run_agg(1'b0, lat);
      check_cnt++;
      if (lat != 13) $display("FAIL wrap_latency got %0d want 13", lat); else pass_cnt++;
      @(negedge clk);
      bus.read_row_arg = 3'd0;
      #1;
      check_cnt++;
      if (bus.adj_fm_wm_row !== {16'hFFFE, 16'h0002, 16'h0000})
         $display("FAIL wrap_row0 got %h want fffe/0002/0000", bus.adj_fm_wm_row);
      else pass_cnt++;
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         bus.read_row_arg = 3'(r);
         #1;
         for (int k = 0; k < WC; k++) begin
            check_cnt++;
            if (bus.adj_fm_wm_row[k] !== exp_row[r][k])
               $display("FAIL wrap_model r%0d k%0d got %0d want %0d", r, k, bus.adj_fm_wm_row[k], exp_row[r][k]);
            else pass_cnt++;
         end
      end
      finish_serve();
   endtask

   task automatic test_random();
      int lat;
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < 6; i++)
            for (int k = 0; k < WC; k++)
               fm_mem[i][k] = 16'($urandom);
         for (int e = 0; e < NC; e++) begin
            edge_a[e] = $urandom_range(0, 7);
            edge_b[e] = $urandom_range(0, 7);
         end
         load_edges();
         compute_model();
         run_agg(1'b0, lat);
         check_cnt++;
         if (lat != 13) $display("FAIL rand%0d_latency got %0d want 13", it, lat); else pass_cnt++;
         for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            bus.read_row_arg = 3'(r);
            #1;
            for (int k = 0; k < WC; k++) begin
               check_cnt++;
               if (bus.adj_fm_wm_row[k] !== exp_row[r][k])
                  $display("FAIL rand%0d_model r%0d k%0d got %0d want %0d", it, r, k, bus.adj_fm_wm_row[k], exp_row[r][k]);
               else pass_cnt++;
            end
         end
         finish_serve();
      end
   endtask

   task automatic test_handshake();
      int  lat;
      bit  busy_drop;
      set_ring_rows();
      for (int e = 0; e < NC; e++) begin
         edge_a[e] = e;
         edge_b[e] = (e + 1) % 6;
      end
      load_edges();
      // start held high for the whole run, argmax_done pulsed during accumulation.
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      lat = -1;
      busy_drop = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         bus.argmax_done = (c == 3);
         if (bus.busy !== 1'b1) busy_drop = 1'b1;
         if (bus.argmax_start === 1'b1) begin
            lat = c;
            break;
         end
      end
      bus.argmax_done = 1'b0;
      check_cnt++;
      if (lat != 13) $display("FAIL hs_latency got %0d want 13", lat); else pass_cnt++;
      check_cnt++;
      if (busy_drop) $display("FAIL hs_busy_held got drop want steady 1"); else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      check_cnt++;
      if (bus.argmax_start !== 1'b1) $display("FAIL hs_no_restart got %b want 1", bus.argmax_start); else pass_cnt++;
      bus.argmax_done = 1'b1;
      @(posedge clk);
      #1;
      bus.argmax_done = 1'b0;
      check_cnt++;
      if (bus.argmax_start !== 1'b0) $display("FAIL hs_done_start got %b want 0", bus.argmax_start); else pass_cnt++;
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL hs_done_busy got %b want 0", bus.busy); else pass_cnt++;
      @(posedge clk);
      #1;
      check_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL hs_restart_busy got %b want 1", bus.busy); else pass_cnt++;
      @(posedge clk);
      #1;
      // Now in the first accumulate cycle: buffer must already be zeroed.
      for (int r = 0; r < 6; r++) begin
         bus.read_row_arg = 3'(r);
         #1;
         check_cnt++;
         if (bus.adj_fm_wm_row !== {16'd0, 16'd0, 16'd0})
            $display("FAIL hs_clear_row%0d got %h want 0", r, bus.adj_fm_wm_row);
         else pass_cnt++;
      end
      bus.start = 1'b0;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.argmax_start === 1'b1) begin
            lat = c;
            break;
         end
      end
      check_cnt++;
      if (lat < 0) $display("FAIL hs_second_run got timeout want argmax_start"); else pass_cnt++;
      finish_serve();
   endtask

   task automatic test_reset_mid();
      set_ring_rows();
      for (int e = 0; e < NC; e++) begin
         edge_a[e] = e;
         edge_b[e] = (e + 1) % 6;
      end
      load_edges();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", bus.busy); else pass_cnt++;
      check_cnt++;
      if (bus.argmax_start !== 1'b0) $display("FAIL rmid_argmax_start got %b want 0", bus.argmax_start); else pass_cnt++;
      check_cnt++;
      if (bus.read_row_fm_wm !== 3'd0) $display("FAIL rmid_read_row got %0d want 0", bus.read_row_fm_wm); else pass_cnt++;
      for (int r = 0; r < 6; r++) begin
         bus.read_row_arg = 3'(r);
         #1;
         check_cnt++;
         if (bus.adj_fm_wm_row !== {16'd0, 16'd0, 16'd0})
            $display("FAIL rmid_row%0d got %h want 0", r, bus.adj_fm_wm_row);
         else pass_cnt++;
      end
      @(posedge clk);
      #1;
      check_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL rmid_stay_idle got %b want 0", bus.busy); else pass_cnt++;
   endtask

   initial begin
      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.argmax_done  = 1'b0;
      bus.read_row_arg = 3'd0;
      bus.coo_in       = '0;
      for (int i = 0; i < 6; i++)
         for (int k = 0; k < WC; k++)
            fm_mem[i][k] = 16'h0;
      test_reset();
      test_ring();
      test_self_loop();
      test_invalid();
      test_wrap();
      test_random();
      test_handshake();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/coo_aggregate_server.md
Name: coo_aggregate_server

Overview:
- Sits between the FM*WM product memory and the argmax stage of the GCN datapath.
- On start, walks the COO edge list and accumulates FM*WM rows into an internal adjacency-aggregated buffer (NUM_OF_NODES x WEIGHT_COLS).
- Then raises argmax_start and serves rows to the argmax block: argmax drives read_row_arg, this block returns adj_fm_wm_row.
- Drops back to idle on argmax_done.

Parameters:
- FEATURE_ROWS, 6, rows in the FM*WM product.
- WEIGHT_COLS, 3, columns per product/aggregated row.
- DOT_PROD_WIDTH, 16, width of each product/aggregated element.
- NUM_OF_NODES, 6, number of graph nodes (buffer rows).
- COO_NUM_OF_COLS, 6, number of edges in the COO list.
- COO_NUM_OF_ROWS, 2, COO rows (row 0 = node a, row 1 = node b).
- COO_BW, $clog2(COO_NUM_OF_COLS), width of a node index and row address.
- EDGE_CNT_WIDTH, $clog2(COO_NUM_OF_COLS)+1, edge counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; FM*WM memory is complete and valid.
- coo_in  in  [0:COO_NUM_OF_ROWS-1][0:COO_NUM_OF_COLS-1] x COO_BW  edge list, stable from start until argmax_done.
- read_row_fm_wm  out  COO_BW  row address into FM*WM memory.
- fm_wm_row_in  in  [0:WEIGHT_COLS-1] x DOT_PROD_WIDTH  FM*WM row, combinational read of read_row_fm_wm.
- argmax_start  out  1  level; buffer valid and serving.
- read_row_arg  in  COO_BW  row requested by argmax.
- adj_fm_wm_row  out  [0:WEIGHT_COLS-1] x DOT_PROD_WIDTH  aggregated row read_row_arg, combinational.
- argmax_done  in  1  argmax finished.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: clears state to IDLE, edge counter to 0, every buffer element to 0, argmax_start to 0, busy to 0, read_row_fm_wm to 0.
- Reset mid-operation aborts immediately with the same values.
- States and transitions:
  - IDLE: start=1 -> CLEAR. Otherwise hold.
  - CLEAR: one cycle. Zero all buffer elements, edge counter = 0. -> ACC_A.
  - ACC_A, edge e = (a = coo_in[0][e], b = coo_in[1][e]): drive read_row_fm_wm = b; buffer[a][k] += fm_wm_row_in[k] for all k. -> ACC_B.
  - ACC_B: drive read_row_fm_wm = a; buffer[b][k] += fm_wm_row_in[k], unless a == b (self-loop, no write). Increment e. If e was COO_NUM_OF_COLS-1 -> SERVE, else -> ACC_A.
  - SERVE: argmax_start = 1 (registered, level). argmax_done=1 -> IDLE, with argmax_start low in IDLE.
- Fixed latency: start sampled at edge 0; argmax_start visible after edge 1 + 2*COO_NUM_OF_COLS (edge 13 by default), independent of self-loops or invalid edges.
- Invalid index: if a or b >= NUM_OF_NODES, the corresponding accumulate is skipped. The cycle is still spent and read_row_fm_wm is still driven.
- Arithmetic: unsigned, modulo 2^DOT_PROD_WIDTH; overflow wraps with no flag.
- adj_fm_wm_row:
  - Always combinational from buffer[read_row_arg], in every state.
  - read_row_arg >= NUM_OF_NODES returns all zeros.
  - Content is only meaningful while argmax_start=1.
- Buffer retained in IDLE after argmax_done until the next CLEAR.
- start while busy=1 is ignored.
- argmax_done outside SERVE is ignored.
- start=1 in the same cycle argmax_done returns the block to IDLE is not captured; start is captured on the following cycle if still high.
- read_row_fm_wm in IDLE/CLEAR/SERVE holds 0.

Test Plan:
- Ring edges (0,1),(1,2),(2,3),(3,4),(4,5),(5,0) with fm_wm row i = {i+1, 10(i+1), 100(i+1)}, start pulse -> argmax_start rises after edge 13; read_row_arg=0 -> {8,80,800}; row 3 -> {8,80,800}; row 1 -> {4,40,400}.
- Self-loop: all edges (2,2), same rows -> row 2 = {18,180,1800} (6 x row 2, counted once per edge); all other rows 0.
- Invalid index: edge (7,1) plus five (0,0) edges -> row 1 gains nothing from node 7; row 7 is never written; read_row_arg=7 -> {0,0,0}; latency still 13.
- Wrap: row 1 = {0xFFFF, 1, 0}, edges (0,1),(0,1), others (5,5) with row 5 = 0 -> row 0 = {0xFFFE, 2, 0}.
- Handshake: start held high through the run -> no restart while busy. argmax_done in ACC_A -> ignored. argmax_done in SERVE -> argmax_start low next cycle, busy=0; start then -> CLEAR zeros the buffer.
- Reset asserted mid ACC_B at edge 3 -> next cycle IDLE, busy=0, argmax_start=0, all rows read 0.
